// File: rtl/naive_bus_arbiter2_pkg.sv
// Shared definitions for naive_bus arbiters: operation kinds, master count
// and a generic round-robin pick usable by wider arbiters.
package nb_arb_pkg;

  typedef enum logic [1:0] {
    NB_IDLE = 2'd0,
    NB_RD   = 2'd1,
    NB_WR   = 2'd2
  } nb_op_e;

  localparam int NB_MASTERS = 2;
  localparam int NB_IDX_W   = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;

  // One-hot pick of the first requester found after 'last', wrapping around.
  function automatic logic [NB_MASTERS-1:0] rr_pick(
    input logic [NB_MASTERS-1:0] want,
    input logic [NB_IDX_W-1:0]   last
  );
    logic [NB_MASTERS-1:0] pick;
    logic [NB_IDX_W-1:0]   idx;
    pick = '0;
    for (int k = 1; k <= NB_MASTERS; k++) begin
      idx = NB_IDX_W'((int'(last) + k) % NB_MASTERS);
      if (want[idx] && (pick == '0)) begin
        pick[idx] = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/naive_bus_arbiter2_if.sv
// naive_bus: split read/write request channels with same-cycle grants and
// one-cycle read data.
interface naive_bus;

  logic        rd_req;
  logic [3:0]  rd_be;
  logic [31:0] rd_addr;
  logic        rd_gnt;
  logic [31:0] rd_data;
  logic        wr_req;
  logic [3:0]  wr_be;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_gnt;

  modport master (
    output rd_req, rd_be, rd_addr,
    input  rd_gnt, rd_data,
    output wr_req, wr_be, wr_addr, wr_data,
    input  wr_gnt
  );

  modport slave (
    input  rd_req, rd_be, rd_addr,
    output rd_gnt, rd_data,
    input  wr_req, wr_be, wr_addr, wr_data,
    output wr_gnt
  );

endinterface

// File: rtl/naive_bus_arbiter2_rr_pick.sv
// Combinational master selector: round-robin after the last winner, or
// lowest index always wins when FIXED_PRIO is set.
module nb_rr_pick
  import nb_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic [NB_MASTERS-1:0] want,
  input  logic [NB_IDX_W-1:0]   last_winner,
  output logic [NB_MASTERS-1:0] sel
);

  if (FIXED_PRIO != 0) begin : g_fixed
    // Isolating the lowest set bit gives master 0 precedence.
    assign sel = want & (~want + NB_MASTERS'(1));
  end else begin : g_rr
    assign sel = rr_pick(want, last_winner);
  end

endmodule

// File: rtl/naive_bus_arbiter2.sv
// Two-master to one-slave naive_bus arbiter: one transaction per cycle, read
// data steered back to the master that issued the read.
module naive_bus_arbiter2
  import nb_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int RD_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  naive_bus.slave       m0,
  naive_bus.slave       m1,
  naive_bus.master      s,
  output logic [1:0]    owner_o,
  output logic [15:0]   gnt_cnt0_o,
  output logic [15:0]   gnt_cnt1_o
);

  if (RD_LATENCY != 1) begin : g_bad_latency
    $error("naive_bus_arbiter2: only RD_LATENCY = 1 is supported");
  end

  logic [NB_MASTERS-1:0] want;
  logic [NB_MASTERS-1:0] sel;
  logic [NB_IDX_W-1:0]   last_winner;
  logic [1:0]            owner;
  logic [15:0]           gnt_cnt0;
  logic [15:0]           gnt_cnt1;
  nb_op_e                op;
  logic                  rd_acc;
  logic                  wr_acc;

  assign want = {m1.rd_req | m1.wr_req, m0.rd_req | m0.wr_req};

  nb_rr_pick #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_pick (
    .want        (want),
    .last_winner (last_winner),
    .sel         (sel)
  );

  // A master asserting both requests gets its read forwarded first.
  always_comb begin
    op        = NB_IDLE;
    s.rd_req  = 1'b0;
    s.rd_be   = '0;
    s.rd_addr = '0;
    s.wr_req  = 1'b0;
    s.wr_be   = '0;
    s.wr_addr = '0;
    s.wr_data = '0;
    if (sel[0]) begin
      if (m0.rd_req) begin
        op        = NB_RD;
        s.rd_req  = 1'b1;
        s.rd_be   = m0.rd_be;
        s.rd_addr = m0.rd_addr;
      end else begin
        op        = NB_WR;
        s.wr_req  = 1'b1;
        s.wr_be   = m0.wr_be;
        s.wr_addr = m0.wr_addr;
        s.wr_data = m0.wr_data;
      end
    end else if (sel[1]) begin
      if (m1.rd_req) begin
        op        = NB_RD;
        s.rd_req  = 1'b1;
        s.rd_be   = m1.rd_be;
        s.rd_addr = m1.rd_addr;
      end else begin
        op        = NB_WR;
        s.wr_req  = 1'b1;
        s.wr_be   = m1.wr_be;
        s.wr_addr = m1.wr_addr;
        s.wr_data = m1.wr_data;
      end
    end
  end

  assign m0.rd_gnt = sel[0] & (op == NB_RD) & s.rd_gnt;
  assign m0.wr_gnt = sel[0] & (op == NB_WR) & s.wr_gnt;
  assign m1.rd_gnt = sel[1] & (op == NB_RD) & s.rd_gnt;
  assign m1.wr_gnt = sel[1] & (op == NB_WR) & s.wr_gnt;

  assign rd_acc = s.rd_req & s.rd_gnt;
  assign wr_acc = s.wr_req & s.wr_gnt;

  // last_winner only moves on accepted transfers so a stalled request keeps
  // its selection; owner marks who receives next cycle's read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_winner <= NB_IDX_W'(1);
      owner       <= 2'b00;
      gnt_cnt0    <= 16'd0;
      gnt_cnt1    <= 16'd0;
    end else begin
      if (rd_acc | wr_acc) begin
        last_winner <= NB_IDX_W'(sel[1]);
        if (sel[0]) gnt_cnt0 <= gnt_cnt0 + 16'd1;
        if (sel[1]) gnt_cnt1 <= gnt_cnt1 + 16'd1;
      end
      owner <= rd_acc ? sel : 2'b00;
    end
  end

  assign m0.rd_data = owner[0] ? s.rd_data : 32'd0;
  assign m1.rd_data = owner[1] ? s.rd_data : 32'd0;

  assign owner_o    = owner;
  assign gnt_cnt0_o = gnt_cnt0;
  assign gnt_cnt1_o = gnt_cnt1;

endmodule

// File: doc/naive_bus_arbiter2.md
Name: naive_bus_arbiter2

Overview:
- Two-master to one-slave arbiter for naive_bus.
- Shares a single-port slave (instruction ROM/RAM, video RAM or a peripheral) between two masters, e.g. core data port and debug/UART loader.
- Grants at most one transaction (read or write) per cycle.
- Tracks the read owner so the slave's 1-cycle-latency rd_data returns only to the master that issued the read.

Parameters:
- FIXED_PRIO, 0, 0 = round-robin between masters; 1 = master 0 always wins.
- RD_LATENCY, 1, slave read-data latency in cycles; only 1 is supported, other values are an elaboration error.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- m0  naive_bus.slave  intf  master 0 port; uses rd_req, rd_be[3:0], rd_addr[31:0], rd_gnt, rd_data[31:0], wr_req, wr_be[3:0], wr_addr[31:0], wr_data[31:0], wr_gnt
- m1  naive_bus.slave  intf  master 1 port; same signals as m0
- s  naive_bus.master  intf  shared slave port; same signals
- owner_o  output  2  debug: bit i = master i owns the pending read-data cycle
- gnt_cnt0_o, gnt_cnt1_o  output  16 each  debug: granted transactions per master, wrapping

Behaviour:
- Protocol rules:
  - A master holds req, addr, be and data stable until it sees gnt in the same cycle.
  - The slave may hold gnt low to stall.
  - Read data appears at the slave exactly 1 cycle after rd_req & rd_gnt.
- Per-master request: want_i = rd_req_i | wr_req_i. If a master asserts both, its read is presented first; its write waits for a later cycle.
- Selection (combinational, same cycle):
  - Only one master wants: that master is selected.
  - Both want, FIXED_PRIO=1: m0 is selected.
  - Both want, FIXED_PRIO=0: master != last_winner is selected.
- Forwarding: the selected master's rd_req/rd_be/rd_addr (or wr_req/wr_be/wr_addr/wr_data) drive s. All other s request lines are 0.
- Grants:
  - m_i.rd_gnt = sel_i & rd_chosen & s.rd_gnt.
  - m_i.wr_gnt = sel_i & wr_chosen & s.wr_gnt.
  - Zero added latency; the unselected master sees gnt=0.
- last_winner register:
  - Updates only on an accepted transaction (s.rd_req&s.rd_gnt or s.wr_req&s.wr_gnt).
  - Holds while the slave stalls, so the selection is stable during a stall and no grant switches mid-request.
- Read return:
  - owner register is set to one-hot(selected) on an accepted read, else 0.
  - Next cycle, m_i.rd_data = owner[i] ? s.rd_data : 0.
  - Back-to-back reads from alternating masters return data correctly every cycle.
- Simultaneous events:
  - An accepted read by m1 in cycle N, while m0 is accepted in N+1, returns data to m1 in N+1 and to m0 in N+2.
  - A write never touches owner.
- Counters: gnt_cnt_i increments on each accepted transaction of master i and wraps 0xFFFF→0.
- Reset (async assert, sync release), all registers cleared:
  - last_winner = m1, so m0 wins the first contest.
  - owner = 0, counters = 0.
  - All m_i.rd_data = 0; grants are 0 whenever no request is present.
- Reset mid-read: owner is cleared and the pending data is dropped; masters must re-issue.

Decomposition:
- Shared package nb_arb_pkg holds:
  - typedef nb_op_e {NB_IDLE, NB_RD, NB_WR}
  - localparam NB_MASTERS=2
  - function rr_pick(want, last) used by future N-master arbiters
- One natural sub-module: nb_rr_pick, the combinational round-robin/fixed-priority selector.
- Owner/data routing and counters stay in the top.

Test Plan:
- Single master: m0 reads 0x0000_0004 from a slave model returning data=addr^0xA5A5_A5A5 → m0.rd_gnt same cycle; m0.rd_data=0xA5A5_A5A1 next cycle; m1.rd_data=0.
- Contention, FIXED_PRIO=0: both read continuously at 0x10/0x20 → grants alternate m0,m1,m0,…; each rd_data matches its own address one cycle later; gnt_cnt0=gnt_cnt1 after 8 cycles (4 each).
- Stall: slave holds rd_gnt=0 for 3 cycles while both request → s.rd_addr stays constant and last_winner unchanged; after the release the same master is granted, then the other.
- Mixed: m0 writes 0x0003_0000 data 0x68 while m1 reads 0x20 → one transaction per cycle; the write is visible at the slave with wr_be preserved; only m1 receives read data; owner_o=2'b10 only in the return cycle.
- FIXED_PRIO=1: both request continuously for 5 cycles → m0 granted 5 times and m1 zero times; m1 granted once m0 drops its request.
- Reset mid-read: assert rst_n low in the data-return cycle → rd_data of both masters = 0, owner_o=0, counters 0; the first grant after release goes to m0.
